// File: rtl/if_id_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_pkg
// Description : Shared types and constants for the IF/ID skid pipeline
//               register: state encoding, MIPS NOP encoding and default
//               data-path widths.
// Revision    : 1.0 - initial release
// ============================================================================
package if_id_pkg;

    // EMPTY: main and skid empty; ONE: main full; TWO: main and skid full.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int unsigned IW_DEF = 32;
    localparam int unsigned AW_DEF = 32;
    localparam int unsigned CW_DEF = 16;

    // sll $0,$0,0
    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage : if_id_pkg
`default_nettype wire

// File: rtl/if_id_skid_if.sv
`default_nettype none
// ============================================================================
// Module      : if_id_skid_if
// Description : Fetch-side and decode-side handshake bundle of the IF/ID
//               stage plus the stall counter readout.
//   slave  : the IF/ID register (receives in_*, drives out_* / in_ready)
//   master : the environment (fetch + decode)
// Revision    : 1.0 - initial release
// ============================================================================
interface if_id_skid_if #(
    parameter int IW = 32,
    parameter int AW = 32,
    parameter int CW = 16
) ();
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_instr;
    logic [AW-1:0] in_npc;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_npc;
    logic [CW-1:0] stall_cnt;

    modport slave (
        input  in_valid, in_instr, in_npc, out_ready,
        output in_ready, out_valid, out_instr, out_npc, stall_cnt
    );

    modport master (
        output in_valid, in_instr, in_npc, out_ready,
        input  in_ready, out_valid, out_instr, out_npc, stall_cnt
    );
endinterface : if_id_skid_if
`default_nettype wire

// File: rtl/if_id_skid_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its all-ones value.
//   clk   in  clock
//   rst_n in  asynchronous active-low reset (clears the count)
//   inc   in  count enable
//   cnt   out current count, CW bits
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CW = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          inc,
    output logic      [CW-1:0] cnt
);
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule : sat_counter
`default_nettype wire

// File: rtl/if_id_skid.sv
`default_nettype none
// ============================================================================
// Module      : if_id_skid
// Description : IF/ID pipeline register with valid/ready handshake, one-entry
//               skid buffer, synchronous flush with NOP insertion and a
//               saturating back-pressure counter.
//   clk   in  clock
//   rst_n in  asynchronous active-low reset
//   flush in  synchronous kill of held and incoming beats
//   bus   slave modport: in_valid/in_ready/in_instr/in_npc from fetch,
//         out_valid/out_ready/out_instr/out_npc to decode, stall_cnt
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_skid
    import if_id_pkg::*;
#(
    parameter int          IW        = IW_DEF,
    parameter int          AW        = AW_DEF,
    parameter int          CW        = CW_DEF,
    parameter logic [IW-1:0] NOP_INSTR = IW'(MIPS_NOP)
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    input  wire logic  flush,
    if_id_skid_if.slave bus
);
    state_t        state_q,      state_d;
    logic [IW-1:0] main_instr_q, main_instr_d;
    logic [AW-1:0] main_npc_q,   main_npc_d;
    logic [IW-1:0] skid_instr_q, skid_instr_d;
    logic [AW-1:0] skid_npc_q,   skid_npc_d;
    // Handshake outputs are registered copies of the next-state decode so
    // neither depends combinationally on any input.
    logic          in_ready_q,   in_ready_d;
    logic          out_valid_q,  out_valid_d;

    logic accept;
    logic deliver;

    assign accept  = bus.in_valid & in_ready_q;
    assign deliver = out_valid_q & bus.out_ready;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_npc_d   = main_npc_q;
        skid_instr_d = skid_instr_q;
        skid_npc_d   = skid_npc_q;

        if (flush) begin
            // Any beat accepted this cycle is dropped along with held ones.
            state_d      = EMPTY;
            main_instr_d = NOP_INSTR;
            main_npc_d   = '0;
            skid_instr_d = '0;
            skid_npc_d   = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d      = ONE;
                        main_instr_d = bus.in_instr;
                        main_npc_d   = bus.in_npc;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        main_instr_d = bus.in_instr;
                        main_npc_d   = bus.in_npc;
                    end else if (accept) begin
                        state_d      = TWO;
                        skid_instr_d = bus.in_instr;
                        skid_npc_d   = bus.in_npc;
                    end else if (deliver) begin
                        state_d      = EMPTY;
                        main_instr_d = NOP_INSTR;
                        main_npc_d   = '0;
                    end
                end
                TWO: begin
                    // in_ready is low here, so no new beat can arrive.
                    if (deliver) begin
                        state_d      = ONE;
                        main_instr_d = skid_instr_q;
                        main_npc_d   = skid_npc_q;
                        skid_instr_d = '0;
                        skid_npc_d   = '0;
                    end
                end
                default: begin
                    state_d      = EMPTY;
                    main_instr_d = NOP_INSTR;
                    main_npc_d   = '0;
                    skid_instr_d = '0;
                    skid_npc_d   = '0;
                end
            endcase
        end

        in_ready_d  = (state_d != TWO);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            main_instr_q <= NOP_INSTR;
            main_npc_q   <= '0;
            skid_instr_q <= '0;
            skid_npc_q   <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_npc_q   <= main_npc_d;
            skid_instr_q <= skid_instr_d;
            skid_npc_q   <= skid_npc_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
        end
    end

    sat_counter #(
        .CW (CW)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid_q & ~bus.out_ready),
        .cnt   (bus.stall_cnt)
    );

    // The main register is forced to NOP/0 whenever it is empty, so it can
    // drive the outputs directly.
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = main_instr_q;
    assign bus.out_npc   = main_npc_q;
endmodule : if_id_skid
`default_nettype wire

// File: tb/tb_if_id_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_skid
// Description : Directed self-checking bench for if_id_skid with a
//               scoreboard queue of accepted beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_skid;
    import if_id_pkg::*;

    localparam int CW  = 4;
    localparam int SAT = 15;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    always #5 clk = ~clk;

    if_id_skid_if #(.IW(32), .AW(32), .CW(CW)) bus ();

    if_id_skid #(
        .IW        (32),
        .AW        (32),
        .CW        (CW),
        .NOP_INSTR (MIPS_NOP)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    int          tests = 0;
    int          fails = 0;
    logic [63:0] sb[$];
    int          m_cnt = 0;
    logic        prev_pend = 1'b0;
    logic [63:0] prev_beat = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called #1 after a posedge with inputs for the coming edge already set.
    task automatic cycle();
        logic        acc;
        logic        dlv;
        logic        stall;
        logic [63:0] beat;
        logic [63:0] exp_beat;
        chk("out_valid", {63'b0, bus.out_valid}, {63'b0, (sb.size() > 0)});
        chk("in_ready",  {63'b0, bus.in_ready},  {63'b0, (sb.size() < 2)});
        chk("stall_cnt", {60'b0, bus.stall_cnt}, 64'(m_cnt));
        if (sb.size() == 0)
            chk("nop_out", {bus.out_instr, bus.out_npc}, {MIPS_NOP, 32'h0});
        else
            chk("out_head", {bus.out_instr, bus.out_npc}, sb[0]);
        if (prev_pend) begin
            chk("proto_valid", {63'b0, bus.in_valid}, 64'd1);
            chk("proto_data", {bus.in_instr, bus.in_npc}, prev_beat);
        end
        beat  = {bus.in_instr, bus.in_npc};
        acc   = bus.in_valid & (sb.size() < 2);
        stall = (sb.size() > 0) & ~bus.out_ready;
        dlv   = (sb.size() > 0) & bus.out_ready;
        if (dlv) begin
            exp_beat = sb.pop_front();
            chk("deliver", {bus.out_instr, bus.out_npc}, exp_beat);
        end
        prev_pend = bus.in_valid & ~acc & ~flush;
        prev_beat = beat;
        @(posedge clk);
        if (stall && m_cnt < SAT) m_cnt++;
        if (flush) sb.delete();
        else if (acc) sb.push_back(beat);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] npc,
                         input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.in_npc    = npc;
        bus.out_ready = ordy;
        flush         = fl;
        cycle();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_out_valid"}, {63'b0, bus.out_valid}, 64'd0);
        chk({tag, "_out_instr"}, {32'b0, bus.out_instr}, 64'h0);
        chk({tag, "_out_npc"},   {32'b0, bus.out_npc},   64'h0);
        chk({tag, "_in_ready"},  {63'b0, bus.in_ready},  64'd1);
        chk({tag, "_stall_cnt"}, {60'b0, bus.stall_cnt}, 64'd0);
    endtask

    // Reset asserted between edges; outputs must clear with no clock edge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        reset_checks("async_rst");
        sb.delete();
        m_cnt     = 0;
        prev_pend = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_npc    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks("rst");
        rst_n = 1'b1;

        // Idle
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Streaming, one beat per cycle
        drive(1'b1, 32'h8C01_0004, 32'd4,  1'b1, 1'b0);
        drive(1'b1, 32'h0022_1820, 32'd8,  1'b1, 1'b0);
        drive(1'b1, 32'h1000_FFFF, 32'd12, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Back-pressure: fill main and skid, hold, then drain
        drive(1'b1, 32'hAAAA_0001, 32'd4, 1'b0, 1'b0);
        drive(1'b1, 32'hBBBB_0002, 32'd8, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'hDEAD_BEEF, 32'h55, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush while TWO with a beat presented
        drive(1'b1, 32'h8C02_0008, 32'd20, 1'b0, 1'b0);
        drive(1'b1, 32'h0043_2020, 32'd24, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 32'hCCCC_0003, 32'd16, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush in ONE: deliver survives, the same-cycle accept is discarded
        drive(1'b1, 32'hD0D0_0004, 32'd28, 1'b1, 1'b0);
        drive(1'b1, 32'hE0E0_0005, 32'd32, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Saturation after a mid-cycle reset; beat in the release cycle
        async_reset();
        rst_n = 1'b1;
        drive(1'b1, 32'hF0F0_0006, 32'd36, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("stall_sat", {60'b0, bus.stall_cnt}, 64'(SAT));
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Deliver-and-accept in ONE replaces main
        drive(1'b1, 32'h1111_0007, 32'd40, 1'b0, 1'b0);
        drive(1'b1, 32'h2222_0008, 32'd44, 1'b1, 1'b0);
        chk("one_replace", {bus.out_instr, bus.out_npc}, {32'h2222_0008, 32'd44});
        chk("one_in_ready", {63'b0, bus.in_ready}, 64'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule : tb_if_id_skid
`default_nettype wire

// File: doc/if_id_skid.md
Name: if_id_skid

Overview:
- Parametrised IF/ID pipeline register for the MIPS pipeline, successor to the plain clocked instr/npc latch.
- Adds a valid/ready handshake, a one-entry skid buffer so that in_ready comes straight from a flop, and synchronous flush with NOP insertion.
- Adds a saturating stall counter for performance debug.
- Sits between the fetch stage (PC/instruction memory) and the decode stage.

Parameters:
- IW, 32, instruction width in bits.
- AW, 32, next-PC width in bits.
- CW, 16, stall counter width in bits.
- NOP_INSTR, 32'h0000_0000, value driven on out_instr whenever out_valid=0 (MIPS sll $0,$0,0). Width IW.

Ports:
- clk  in  1  clock; all flops update on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous kill of all held and incoming beats (branch/jump redirect).
- in_valid  in  1  fetch presents a beat.
- in_ready  out  1  stage can accept; driven directly from a flop (equals !skid_valid).
- in_instr  in  IW  fetched instruction.
- in_npc  in  AW  PC+4 of the fetched instruction.
- out_valid  out  1  decode beat valid.
- out_ready  in  1  decode accepts the beat.
- out_instr  out  IW  instruction to decode.
- out_npc  out  AW  next PC to decode.
- stall_cnt  out  CW  saturating count of back-pressure cycles.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Definitions: accept = in_valid & in_ready; deliver = out_valid & out_ready.
- Reset values: state EMPTY, out_valid=0, out_instr=NOP_INSTR, out_npc=0, in_ready=1, skid contents 0, stall_cnt=0.
- Reset is asserted and released asynchronously; a beat presented in the reset-release cycle is accepted normally.
- Storage: a main register (drives the outputs) and one skid register.
- State EMPTY (main and skid empty):
  - accept -> ONE, main<=in.
  - otherwise hold.
- State ONE (main full):
  - accept & deliver -> ONE, main<=in.
  - accept & !deliver -> TWO, skid<=in.
  - !accept & deliver -> EMPTY, main<=NOP_INSTR/0.
  - otherwise hold.
- State TWO (main and skid full, in_ready=0):
  - deliver -> ONE, main<=skid, skid cleared to 0.
  - otherwise hold.
- Latency and throughput: 1 cycle from accept to out_valid when EMPTY; sustained 1 beat/cycle with out_ready=1; no combinational path from out_ready to in_ready.
- Ordering: beats leave in acceptance order; the skid beat is always older than any new input.
- Data invariants:
  - out_instr = NOP_INSTR and out_npc = 0 whenever out_valid=0.
  - Output data is stable while out_valid & !out_ready.
- Flush (synchronous, highest priority):
  - Next state is EMPTY; main and skid are cleared (out_instr<=NOP_INSTR, out_npc<=0).
  - A beat accepted in the same cycle is discarded: upstream treats it as consumed, and it never appears at the output.
  - A deliver in the flush cycle still counts as delivered (decode already sampled it).
  - in_ready=1 the cycle after flush.
- Flush while in TWO: both beats are dropped; no partial drain.
- stall_cnt:
  - +1 every cycle with out_valid & !out_ready; saturates at 2^CW-1 (no wrap).
  - Not cleared by flush; cleared only by reset.
- Inputs are not sampled when in_ready=0; in_instr/in_npc may change freely then.
- Upstream must hold in_valid and data stable until accept (protocol rule; asserted in the bench, not checked in RTL).

Decomposition:
- Package if_id_pkg:
  - state enum {EMPTY, ONE, TWO}.
  - MIPS_NOP constant (32'h0000_0000), used as the NOP_INSTR default.
  - Default width constants IW/AW.
- One natural sub-module: sat_counter, parametrised by CW, with inputs inc and rst_n and output cnt; used for stall_cnt.
- Main/skid data path stays inline.

Test Plan:
- Reset then idle.
  - Stimulus: rst_n=0 mid-stream, then release.
  - Required: out_valid=0, out_instr=0x00000000, out_npc=0, in_ready=1, stall_cnt=0 immediately on assertion, without waiting for a clock edge.
- Streaming.
  - Stimulus: out_ready=1; feed instr 0x8C010004, 0x00221820, 0x1000FFFF with npc 4, 8, 12 on consecutive cycles.
  - Required: each appears one cycle later, in order, with one beat per cycle and no bubbles.
- Back-pressure.
  - Stimulus: out_ready=0 while two beats A(npc 4), B(npc 8) are accepted.
  - Required:
    - state TWO; in_ready=0 on the cycle after B.
    - out holds A.
    - stall_cnt counts every cycle.
    - Raise out_ready: A then B delivered, in_ready=1 one cycle after A leaves.
- Flush in TWO with simultaneous input.
  - Stimulus: flush=1 plus in_valid with C(npc 16).
  - Required:
    - next cycle out_valid=0, out_instr=0x00000000, in_ready=1.
    - A, B, C never appear.
    - stall_cnt unchanged by the flush.
- Counter saturation.
  - Stimulus: CW=4, hold out_valid=1, out_ready=0 for 20 cycles.
  - Required: stall_cnt stops at 15 and stays 15.
- Deliver-and-accept in ONE.
  - Stimulus: out_ready=1 and in_valid=1 on the same cycle.
  - Required: the state remains ONE, and the main register is replaced by the new beat.
